blit_executor: RTL and testbench
================================

// Module: blit_executor
// PURPOSE
//  Downstream consumer of the blitter command FIFO. Pops 96-bit commands, decodes them,
//  and walks FILL_RECT rectangles row-major. Emits one 8bpp pixel write per accepted
//  beat on a valid/ready port to the framebuffer memory arbiter.
// PARAMETERS
//  ADDR_W  32  pixel write byte-address width
//  DIM_W   16  width of x/y/width/height/stride fields
// PORTS
//  clock          in   1   system clock
//  reset          in   1   synchronous, active-high
//  cmd_in         in   96  command word at FIFO head
//  cmd_in_valid   in   1   FIFO head holds a command
//  next_cmd       out  1   one-cycle pop strobe to FIFO
//  pix_addr       out  32  pixel byte address
//  pix_data       out  8   pixel colour
//  pix_valid      out  1   pixel write request
//  pix_ready      in   1   arbiter accepts pixel this cycle
//  busy           out  1   command in progress (state != IDLE)
//  cmd_error      out  1   sticky: unknown opcode seen
// BEHAVIOUR
//  Clock and reset: reset is synchronous, active-high; clock is clock.
//  Reset: state=IDLE, next_cmd=0, pix_valid=0, busy=0, cmd_error=0, dest_base=0, dest_stride=0.
//   Asserting reset mid-rectangle abandons it; no further pixel beats are issued.
//  Opcode is cmd_in[95:92]. Field layout by opcode:
//   0 NOP       ignored.
//   1 SET_DEST  dest_base=cmd_in[31:0], dest_stride=cmd_in[47:32].
//   2 FILL_RECT x=[15:0], y=[31:16], w=[47:32], h=[63:48], colour=[71:64].
//   3..15       sets cmd_error; otherwise treated as NOP.
//  FSM: IDLE -> POP -> (SETUP -> DRAW ->) WAIT -> IDLE.
//   IDLE:  when cmd_in_valid=1, latch cmd_in and go to POP.
//   POP:   drive next_cmd=1 for exactly this cycle.
//          NOP, SET_DEST and unknown opcodes are applied here, then go to WAIT.
//          FILL_RECT with w=0 or h=0 goes to WAIT; other FILL_RECT goes to SETUP.
//   SETUP: row_addr <= dest_base + y*dest_stride (registered 16x16 multiply, one cycle).
//          Set xc=0, rows_left=h, then go to DRAW.
//   DRAW:  pix_valid=1, pix_addr=row_addr+x+xc, pix_data=colour.
//          On pix_valid&&pix_ready: if xc==w-1 then xc=0, row_addr+=dest_stride, rows_left-=1;
//          otherwise xc+=1.
//          The last pixel is accepted at xc==w-1 with rows_left==1; then go to WAIT.
//   WAIT:  one dead cycle; go to IDLE.
//          The FIFO updates cmd_in_valid one cycle after the pop, so cmd_in_valid is
//          ignored in POP and in this cycle.
//  Handshake: pix_addr and pix_data are held stable while pix_valid=1 && pix_ready=0.
//   pix_valid never drops without an accept, except on reset.
//  Arithmetic: address sums are modulo 2^ADDR_W (wrap-around, no error).
//   x+xc is zero-extended to ADDR_W.
//  Throughput: 1 pixel/cycle with pix_ready held high.
//   Command overhead: 3 cycles (POP, SETUP, WAIT) for FILL_RECT; 2 for other opcodes.
//  A SET_DEST arriving after a FILL_RECT is not decoded until that rectangle completes.
//   The rectangle in flight always uses the prior dest_base and dest_stride.
//  next_cmd fires exactly once per command, including NOP and error commands.
// TESTING
//  1. SET_DEST base=0x1000 stride=320; FILL_RECT x=2 y=1 w=3 h=2 colour=0x5A; pix_ready=1
//     -> addrs 0x1142,0x1143,0x1144,0x1282,0x1283,0x1284, all data 0x5A.
//     Then busy=0; next_cmd pulsed exactly twice.
//  2. Same rectangle with pix_ready toggling 1,0,0,1,... -> identical address sequence.
//     pix_addr and pix_data are stable during every stall; exactly 6 beats.
//  3. FILL_RECT w=0 h=5, then FILL_RECT w=5 h=0 -> zero pix_valid cycles.
//     Two next_cmd pulses; busy=1 for exactly 2 cycles per command.
//  4. Opcode 0xF -> cmd_error=1 and stays 1 through later good commands.
//     Cleared only by reset; the pop still occurs.
//  5. Base 0xFFFFFFFE, stride 0, FILL_RECT x=0 w=4 h=1 -> addrs FFFFFFFE, FFFFFFFF, 0, 1.
//  6. Assert reset during the 3rd pixel of a 4x4 fill -> next cycle pix_valid=0, busy=0,
//     cmd_error=0. No further beats until a new command arrives.

Source files
------------

// File: rtl/blit_executor.sv
// Blitter command executor: pops commands from the FIFO head, tracks the destination surface,
// and walks FILL_RECT rectangles row-major, issuing one 8bpp pixel write per accepted beat.
module blit_executor #(
    parameter int ADDR_W = 32,
    parameter int DIM_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [95:0]       cmd_in,
    input  logic              cmd_in_valid,
    output logic              next_cmd,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              busy,
    output logic              cmd_error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        SETUP = 3'd2,
        DRAW  = 3'd3,
        WAIT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_SET_DEST  = 4'd1;
    localparam logic [3:0] OP_FILL_RECT = 4'd2;

    state_t              state_reg, state_next;
    logic [95:0]         cmd_reg;
    logic [ADDR_W-1:0]   dest_base_reg;
    logic [DIM_W-1:0]    dest_stride_reg;
    logic [ADDR_W-1:0]   row_addr_reg;
    logic [DIM_W-1:0]    xc_reg;
    logic [DIM_W-1:0]    rows_left_reg;
    logic                cmd_error_reg;

    // Decoded fields of the latched command.
    logic [3:0]          opcode;
    logic [DIM_W-1:0]    fx, fy, fw, fh;
    logic [7:0]          colour;
    logic [2*DIM_W-1:0]  row_offset;
    logic [DIM_W:0]      col;
    logic                row_end;
    logic                last_pixel;
    logic                accept;
    logic                unused_bits;

    assign opcode      = cmd_reg[95:92];
    assign fx          = cmd_reg[15:0];
    assign fy          = cmd_reg[31:16];
    assign fw          = cmd_reg[47:32];
    assign fh          = cmd_reg[63:48];
    assign colour      = cmd_reg[71:64];
    assign unused_bits = ^cmd_reg[91:72];

    assign row_offset  = fy * dest_stride_reg;
    // x+xc keeps its carry so a column past 0xFFFF still lands at the right byte.
    assign col         = {1'b0, fx} + {1'b0, xc_reg};
    assign row_end     = (xc_reg == fw - DIM_W'(1));
    assign last_pixel  = row_end && (rows_left_reg == DIM_W'(1));
    assign accept      = pix_valid && pix_ready;

    assign pix_addr    = row_addr_reg + ADDR_W'(col);
    assign pix_data    = colour;
    assign busy        = (state_reg != IDLE);
    assign cmd_error   = cmd_error_reg;

    always_comb begin
        state_next = state_reg;
        next_cmd   = 1'b0;
        pix_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_in_valid) state_next = POP;
            end
            POP: begin
                next_cmd = 1'b1;
                if (opcode == OP_FILL_RECT && fw != '0 && fh != '0)
                    state_next = SETUP;
                else
                    state_next = WAIT;
            end
            SETUP: state_next = DRAW;
            DRAW: begin
                pix_valid = 1'b1;
                if (pix_ready && last_pixel) state_next = WAIT;
            end
            WAIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            cmd_reg         <= '0;
            dest_base_reg   <= '0;
            dest_stride_reg <= '0;
            row_addr_reg    <= '0;
            xc_reg          <= '0;
            rows_left_reg   <= '0;
            cmd_error_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (cmd_in_valid) cmd_reg <= cmd_in;
                end
                POP: begin
                    if (opcode == OP_SET_DEST) begin
                        dest_base_reg   <= cmd_reg[31:0];
                        dest_stride_reg <= cmd_reg[47:32];
                    end
                    if (opcode > OP_FILL_RECT) cmd_error_reg <= 1'b1;
                end
                SETUP: begin
                    row_addr_reg  <= dest_base_reg + ADDR_W'(row_offset);
                    xc_reg        <= '0;
                    rows_left_reg <= fh;
                end
                DRAW: begin
                    if (accept) begin
                        if (row_end) begin
                            xc_reg        <= '0;
                            row_addr_reg  <= row_addr_reg + {{(ADDR_W-DIM_W){1'b0}}, dest_stride_reg};
                            rows_left_reg <= rows_left_reg - DIM_W'(1);
                        end else begin
                            xc_reg <= xc_reg + DIM_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_blit_executor.sv
// Directed bench for blit_executor: a command table with hand-computed pixel beats,
// plus hand-written sequences for reset state and reset in the middle of a rectangle.
module tb_blit_executor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [95:0] cmd_in = '0;
    logic        cmd_in_valid = 1'b0;
    logic        next_cmd;
    logic [31:0] pix_addr;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        busy;
    logic        cmd_error;

    blit_executor #(.ADDR_W(32), .DIM_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_in       (cmd_in),
        .cmd_in_valid (cmd_in_valid),
        .next_cmd     (next_cmd),
        .pix_addr     (pix_addr),
        .pix_data     (pix_data),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .busy         (busy),
        .cmd_error    (cmd_error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_fail = 0;
    int ready_mode = 0;
    int pops = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;
    logic [31:0] beat_addr[$];
    logic [7:0]  beat_data[$];

    function automatic logic [95:0] mk_set(input logic [31:0] base, input logic [15:0] stride);
        return {4'd1, 44'd0, stride, base};
    endfunction

    function automatic logic [95:0] mk_fill(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] w, input logic [15:0] h,
                                            input logic [7:0] c);
        return {4'd2, 20'd0, c, h, w, y, x};
    endfunction

    function automatic logic [95:0] mk_op(input logic [3:0] op);
        return {op, 92'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ready pattern: mode 0 holds ready high, mode 1 repeats 1,0,0.
    initial begin
        int rcnt = 0;
        forever begin
            @(posedge clock);
            #1;
            rcnt++;
            pix_ready = (ready_mode == 0) ? 1'b1 : ((rcnt % 3) == 0);
        end
    end

    // Monitor: records accepted beats and checks that a stalled beat is held.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_addr = '0;
        logic [7:0]  prev_data = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (next_cmd) pops++;
                if (busy) busy_cnt++;
                if (pix_valid) valid_cnt++;
                if (prev_stall) begin
                    n_cmp++;
                    if (!(pix_valid === 1'b1 && pix_addr === prev_addr && pix_data === prev_data)) begin
                        n_fail++;
                        $display("FAIL stall_hold: got valid=%b addr=%h data=%h expected valid=1 addr=%h data=%h",
                                 pix_valid, pix_addr, pix_data, prev_addr, prev_data);
                    end
                end
                if (pix_valid && pix_ready) begin
                    beat_addr.push_back(pix_addr);
                    beat_data.push_back(pix_data);
                end
                prev_stall = pix_valid && !pix_ready;
                prev_addr  = pix_addr;
                prev_data  = pix_data;
            end
        end
    end

    task automatic send(input logic [95:0] c);
        bit popped = 0;
        bit done = 0;
        @(negedge clock);
        #1;
        cmd_in = c;
        cmd_in_valid = 1'b1;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clock);
            #1;
            if (next_cmd) begin
                popped = 1;
                cmd_in_valid = 1'b0;
            end
            if (popped && !busy) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: got popped=%0d busy=%b expected popped=1 busy=0", popped, busy);
            cmd_in_valid = 1'b0;
        end
    endtask

    typedef struct {
        logic [95:0]       cmd;
        int                mode;
        int                n;
        logic [7:0][31:0]  addrs;
        logic [7:0]        data;
        logic              err;
        int                busy_cycles;   // 0 = not checked
    } vec_t;

    vec_t tbl[11];

    initial begin
        int p0, b0, bc0, v0;

        tbl[0]  = '{mk_set(32'h1000, 16'd320), 0, 0, '0, 8'h00, 1'b0, 2};
        tbl[1]  = '{mk_fill(16'd2, 16'd1, 16'd3, 16'd2, 8'h5A), 0, 6,
                    {32'h0, 32'h0, 32'h1284, 32'h1283, 32'h1282, 32'h1144, 32'h1143, 32'h1142},
                    8'h5A, 1'b0, 9};
        tbl[2]  = '{mk_fill(16'd2, 16'd1, 16'd3, 16'd2, 8'h5A), 1, 6,
                    {32'h0, 32'h0, 32'h1284, 32'h1283, 32'h1282, 32'h1144, 32'h1143, 32'h1142},
                    8'h5A, 1'b0, 0};
        tbl[3]  = '{mk_fill(16'd1, 16'd1, 16'd0, 16'd5, 8'h11), 0, 0, '0, 8'h00, 1'b0, 2};
        tbl[4]  = '{mk_fill(16'd1, 16'd1, 16'd5, 16'd0, 8'h22), 0, 0, '0, 8'h00, 1'b0, 2};
        tbl[5]  = '{mk_op(4'hF), 0, 0, '0, 8'h00, 1'b1, 2};
        tbl[6]  = '{mk_op(4'h0), 0, 0, '0, 8'h00, 1'b1, 2};
        tbl[7]  = '{mk_set(32'hFFFF_FFFE, 16'd0), 0, 0, '0, 8'h00, 1'b1, 2};
        tbl[8]  = '{mk_fill(16'd0, 16'd7, 16'd4, 16'd1, 8'h33), 0, 4,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
                    8'h33, 1'b1, 7};
        tbl[9]  = '{mk_set(32'h10, 16'd5), 0, 0, '0, 8'h00, 1'b1, 2};
        tbl[10] = '{mk_fill(16'hFFFF, 16'd2, 16'd2, 16'd1, 8'h01), 0, 2,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_001A, 32'h0001_0019},
                    8'h01, 1'b1, 5};

        repeat (3) @(negedge clock);
        check("reset_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("reset_busy",      {31'd0, busy},      32'd0);
        check("reset_next_cmd",  {31'd0, next_cmd},  32'd0);
        check("reset_cmd_error", {31'd0, cmd_error}, 32'd0);
        #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            ready_mode = tbl[i].mode;
            p0  = pops;
            b0  = beat_addr.size();
            bc0 = busy_cnt;
            v0  = valid_cnt;
            send(tbl[i].cmd);
            check($sformatf("v%0d_pops", i),  pops - p0, 32'd1);
            check($sformatf("v%0d_beats", i), beat_addr.size() - b0, tbl[i].n);
            for (int k = 0; k < tbl[i].n && b0 + k < beat_addr.size(); k++) begin
                check($sformatf("v%0d_addr%0d", i, k), beat_addr[b0 + k], tbl[i].addrs[k]);
                check($sformatf("v%0d_data%0d", i, k), {24'd0, beat_data[b0 + k]}, {24'd0, tbl[i].data});
            end
            check($sformatf("v%0d_cmd_error", i), {31'd0, cmd_error}, {31'd0, tbl[i].err});
            check($sformatf("v%0d_busy_after", i), {31'd0, busy}, 32'd0);
            if (tbl[i].busy_cycles != 0)
                check($sformatf("v%0d_busy_cycles", i), busy_cnt - bc0, tbl[i].busy_cycles);
            if (tbl[i].mode == 0)
                check($sformatf("v%0d_valid_cycles", i), valid_cnt - v0, tbl[i].n);
        end
        ready_mode = 0;

        // Reset in the middle of a 4x4 fill, while the third pixel is presented.
        send(mk_set(32'h0, 16'd16));
        b0 = beat_addr.size();
        @(negedge clock);
        #1;
        cmd_in = mk_fill(16'd1, 16'd1, 16'd4, 16'd4, 8'hC3);
        cmd_in_valid = 1'b1;
        begin
            bit hit = 0;
            for (int t = 0; t < 50 && !hit; t++) begin
                @(negedge clock);
                #1;
                if (next_cmd) cmd_in_valid = 1'b0;
                if (pix_valid && beat_addr.size() - b0 == 2) hit = 1;
            end
            check("rst_mid_reached", {31'd0, hit}, 32'd1);
        end
        check("rst_mid_addr0", beat_addr[b0],     32'h11);
        check("rst_mid_addr1", beat_addr[b0 + 1], 32'h12);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("rst_mid_pix_valid", {31'd0, pix_valid}, 32'd0);
        check("rst_mid_busy",      {31'd0, busy},      32'd0);
        check("rst_mid_cmd_error", {31'd0, cmd_error}, 32'd0);
        reset = 1'b0;
        v0 = valid_cnt;
        repeat (10) @(negedge clock);
        #1;
        check("rst_mid_no_beats", beat_addr.size() - b0, 32'd2);
        check("rst_mid_no_valid", valid_cnt - v0, 32'd0);

        // Destination registers are cleared by reset: base 0, stride 0.
        b0 = beat_addr.size();
        send(mk_fill(16'd3, 16'd5, 16'd1, 16'd1, 8'h77));
        check("post_rst_beats", beat_addr.size() - b0, 32'd1);
        if (beat_addr.size() > b0)
            check("post_rst_addr", beat_addr[b0], 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
